noc_ni_tx: RTL and testbench

NOC_NI_TX -- requirements
Module: noc_ni_tx

---
 rtl/noc_ni_tx.sv | 135 +++++++++++++
 tb/tb_noc_ni_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_ni_tx.sv
// Network-interface transmitter: frames queued payload bytes into header + body flits
// for one router input port, under credit-based flow control.
module noc_ni_tx (
  input  logic       CLK,
  input  logic       RES,
  input  logic       pkt_start,
  input  logic [1:0] pkt_dest,
  input  logic [2:0] pkt_len,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       credit_in,
  output logic [7:0] port_o,
  output logic       en_o,
  output logic       fifo_full,
  output logic [3:0] fifo_count,
  output logic       busy,
  output logic       err
);
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned DW    = 8;
  localparam logic [2:0]  CREDIT_MAX = 3'd4;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  typedef struct packed {
    logic [1:0] dest;
    logic [2:0] len;
    logic [2:0] seq;
  } hdr_t;

  state_t          state_q, state_d;
  logic [1:0]      dest_q;
  logic [2:0]      len_q;
  logic [2:0]      seq_q;
  logic [2:0]      bcnt_q;
  logic [2:0]      credits_q, credits_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            emit_hdr_c, emit_body_c, emit_c, last_c, push_c, err_set_c;
  logic [DW-1:0]   port_d;
  hdr_t            hdr_c;

  // State register
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt_start) state_d = HEAD;
      HEAD:    if (emit_hdr_c) state_d = BODY;
      BODY:    if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flit emission decisions and next values of the registered outputs
  always_comb begin
    emit_hdr_c  = 1'b0;
    emit_body_c = 1'b0;
    hdr_c       = '{dest: dest_q, len: len_q, seq: seq_q};
    port_d      = port_o;
    case (state_q)
      HEAD: emit_hdr_c  = (credits_q != 3'd0);
      BODY: emit_body_c = (credits_q != 3'd0) && (count_q != CW'(0));
      default: ;
    endcase
    emit_c = emit_hdr_c | emit_body_c;
    last_c = emit_body_c && (bcnt_q == len_q);
    if (emit_hdr_c)       port_d = hdr_c;
    else if (emit_body_c) port_d = mem_q[rd_ptr_q];
  end

  // Credit bookkeeping and protocol-error detection
  always_comb begin
    push_c    = wr_en && (count_q != CW'(DEPTH));
    credits_d = credits_q;
    case ({emit_c, credit_in})
      2'b10:   credits_d = credits_q - 3'd1;
      2'b01:   credits_d = (credits_q == CREDIT_MAX) ? credits_q : credits_q + 3'd1;
      default: credits_d = credits_q;
    endcase
    err_set_c = (credit_in && !emit_c && (credits_q == CREDIT_MAX))
              || (wr_en && (count_q == CW'(DEPTH)))
              || (pkt_start && (state_q != IDLE));
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      port_o    <= '0;
      en_o      <= 1'b0;
      err       <= 1'b0;
      dest_q    <= '0;
      len_q     <= '0;
      seq_q     <= '0;
      bcnt_q    <= '0;
      credits_q <= CREDIT_MAX;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      port_o    <= port_d;
      en_o      <= emit_c;
      credits_q <= credits_d;
      if (err_set_c) err <= 1'b1;
      if ((state_q == IDLE) && pkt_start) begin
        dest_q <= pkt_dest;
        len_q  <= pkt_len;
      end
      if (emit_hdr_c)       bcnt_q <= '0;
      else if (emit_body_c) bcnt_q <= bcnt_q + 3'd1;
      if (last_c)      seq_q    <= seq_q + 3'd1;
      if (push_c)      wr_ptr_q <= wr_ptr_q + PW'(1);
      if (emit_body_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_c) - CW'(emit_body_c);
    end
  end

  // Payload storage needs no reset: pointers and count define validity
  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign fifo_count = count_q;
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_noc_ni_tx.sv
// Directed bench for noc_ni_tx: framing, credit and underrun stalls, overflow, seq wrap, reset.
module tb_noc_ni_tx;
  logic       CLK, RES;
  logic       pkt_start, wr_en, credit_in;
  logic [1:0] pkt_dest;
  logic [2:0] pkt_len;
  logic [7:0] wr_data;
  logic [7:0] port_o;
  logic       en_o, fifo_full, busy, err;
  logic [3:0] fifo_count;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [2:0] seq_m  = 3'd0;

  noc_ni_tx dut (
    .CLK(CLK), .RES(RES), .pkt_start(pkt_start), .pkt_dest(pkt_dest), .pkt_len(pkt_len),
    .wr_en(wr_en), .wr_data(wr_data), .credit_in(credit_in), .port_o(port_o), .en_o(en_o),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .busy(busy), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  // Push len+1 bytes (optional), start a packet, return credits as flits leave, check every flit
  task automatic send_pkt(input logic [1:0] d, input logic [2:0] l, input logic [7:0] base,
                          input bit do_push);
    int nflit;
    int cyc;
    logic [7:0] exp;
    if (do_push)
      for (int i = 0; i <= int'(l); i++) push(8'(base + 8'(i)));
    pkt_start = 1'b1; pkt_dest = d; pkt_len = l;
    step();
    pkt_start = 1'b0;
    credit_in = 1'b1;
    nflit = 0;
    cyc = 0;
    while (busy && cyc < 40) begin
      step();
      cyc++;
      if (en_o) begin
        exp = (nflit == 0) ? {d, l, seq_m} : 8'(base + 8'(nflit - 1));
        check("flit", 32'(port_o), 32'(exp));
        nflit++;
      end
    end
    credit_in = 1'b0;
    check("pkt_flits", 32'(nflit), 32'(int'(l) + 2));
    check("pkt_done", 32'(busy), 32'd0);
    seq_m = seq_m + 3'd1;
  endtask

  initial begin
    RES = 1'b0; pkt_start = 1'b0; wr_en = 1'b0; credit_in = 1'b0;
    pkt_dest = '0; pkt_len = '0; wr_data = '0;
    #12;
    check("rst_port", 32'(port_o), 32'h0);
    check("rst_en", 32'(en_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    #5 RES = 1'b1;

    // Basic packet: header then three bytes on consecutive cycles
    push(8'h11); push(8'h22); push(8'h33);
    check("b_cnt", 32'(fifo_count), 32'd3);
    pkt_start = 1'b1; pkt_dest = 2'd2; pkt_len = 3'd2;
    step();
    pkt_start = 1'b0;
    check("b_busy", 32'(busy), 32'd1);
    check("b_en0", 32'(en_o), 32'd0);
    step(); check("b_hdr", 32'({en_o, port_o}), 32'h190);
    step(); check("b_d0", 32'({en_o, port_o}), 32'h111);
    step(); check("b_d1", 32'({en_o, port_o}), 32'h122);
    step(); check("b_d2", 32'({en_o, port_o}), 32'h133);
    check("b_idle", 32'(busy), 32'd0);
    check("b_cnt0", 32'(fifo_count), 32'd0);
    step(); check("b_en_off", 32'(en_o), 32'd0);
    seq_m = 3'd1;
    credit_in = 1'b1; repeat (4) step(); credit_in = 1'b0;
    check("b_err", 32'(err), 32'd0);

    // Credit stall: 4 credits cover header + 3 bytes
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + 8'(i)));
    check("c_full", 32'(fifo_full), 32'd1);
    check("c_cnt", 32'(fifo_count), 32'd8);
    pkt_start = 1'b1; pkt_dest = 2'd1; pkt_len = 3'd7;
    step();
    pkt_start = 1'b0;
    step(); check("c_hdr", 32'({en_o, port_o}), 32'h179);
    for (int i = 0; i < 3; i++) begin
      step(); check("c_byte", 32'({en_o, port_o}), 32'(9'h100 | 9'(8'hA0 + 8'(i))));
    end
    step(); check("c_stall0", 32'(en_o), 32'd0);
    step(); check("c_stall1", 32'({en_o, port_o}), 32'h0A2);
    credit_in = 1'b1; step(); credit_in = 1'b0;
    check("c_cred_edge", 32'(en_o), 32'd0);
    step(); check("c_one", 32'({en_o, port_o}), 32'h1A3);
    step(); check("c_stall2", 32'(en_o), 32'd0);
    credit_in = 1'b1;
    step(); check("c_refill", 32'(en_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); check("c_rest", 32'({en_o, port_o}), 32'(9'h100 | 9'(8'hA4 + 8'(i))));
    end
    credit_in = 1'b0;
    check("c_idle", 32'(busy), 32'd0);
    seq_m = 3'd2;
    credit_in = 1'b1; repeat (3) step(); credit_in = 1'b0;

    // Underrun: header alone, then one flit per push
    pkt_start = 1'b1; pkt_dest = 2'd3; pkt_len = 3'd3;
    step();
    pkt_start = 1'b0;
    step(); check("u_hdr", 32'({en_o, port_o}), 32'h1DA);
    step(); check("u_empty", 32'(en_o), 32'd0);
    for (int b = 0; b < 4; b++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + 8'(b)); credit_in = 1'b1;
      step();
      wr_en = 1'b0; credit_in = 1'b0;
      check("u_push", 32'(en_o), 32'd0);
      step(); check("u_byte", 32'({en_o, port_o}), 32'(9'h100 | 9'(8'hC0 + 8'(b))));
    end
    check("u_idle", 32'(busy), 32'd0);
    seq_m = 3'd3;
    credit_in = 1'b1; step(); credit_in = 1'b0;
    check("u_err", 32'(err), 32'd0);

    // Overflow: ninth write dropped and flagged
    for (int i = 0; i < 8; i++) push(8'(8'hE0 + 8'(i)));
    check("o_full", 32'(fifo_full), 32'd1);
    check("o_err0", 32'(err), 32'd0);
    push(8'hE8);
    check("o_cnt", 32'(fifo_count), 32'd8);
    check("o_err1", 32'(err), 32'd1);
    send_pkt(2'd0, 3'd7, 8'hE0, 1'b0);
    check("o_drained", 32'(fifo_count), 32'd0);
    step(); check("o_no9th", 32'(en_o), 32'd0);

    // Reset during the second payload byte
    push(8'h51); push(8'h52); push(8'h53);
    pkt_start = 1'b1; pkt_dest = 2'd1; pkt_len = 3'd2;
    step();
    pkt_start = 1'b0;
    step(); step();
    step(); check("r_b1", 32'({en_o, port_o}), 32'h152);
    #2 RES = 1'b0;
    #1;
    check("r_en", 32'(en_o), 32'd0);
    check("r_port", 32'(port_o), 32'h0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_cnt", 32'(fifo_count), 32'd0);
    check("r_err", 32'(err), 32'd0);
    #2 RES = 1'b1;
    seq_m = 3'd0;
    step(); check("r_quiet", 32'(en_o), 32'd0);

    // Seq wrap over nine one-byte packets
    for (int p = 0; p < 9; p++) send_pkt(2'(p), 3'd0, 8'(8'h10 * 8'(p)), 1'b1);
    check("s_err", 32'(err), 32'd0);

    // Second pkt_start while busy: flagged, header keeps latched dest
    push(8'h77);
    pkt_start = 1'b1; pkt_dest = 2'd0; pkt_len = 3'd0;
    step();
    pkt_dest = 2'd3;
    step();
    pkt_start = 1'b0;
    check("p_err", 32'(err), 32'd1);
    check("p_hdr", 32'({en_o, port_o}), 32'h101);
    step(); check("p_byte", 32'({en_o, port_o}), 32'h177);
    check("p_idle", 32'(busy), 32'd0);

    // Credit return at full count is an error
    #2 RES = 1'b0;
    #1 check("k_err0", 32'(err), 32'd0);
    #2 RES = 1'b1;
    credit_in = 1'b1; step(); credit_in = 1'b0;
    check("k_err1", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
